// File: rtl/i_cache_line_adaptor_pkg.sv
// Shared types and sizing for the I-cache line-fill adaptor.
// Line geometry, beat counter width and FSM state encoding.
package cache_pkg;

    localparam int ADDR_W      = 32;
    localparam int LINE_W      = 256;
    localparam int BEAT_W      = 64;
    localparam int BEATS       = LINE_W / BEAT_W;
    localparam int OFFSET_BITS = 5;
    localparam int CNT_W       = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } adaptor_state_e;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [LINE_W-1:0] line_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/i_cache_line_adaptor_if.sv
// Cache-side line request bus and memory-side burst read bus.
// master drives the request, slave returns the data.
interface cache_line_if;
    import cache_pkg::*;

    logic  line_read;
    addr_t line_addr;
    line_t line_rdata;
    logic  line_resp;

    modport master (
        output line_read,
        output line_addr,
        input  line_rdata,
        input  line_resp
    );

    modport slave (
        input  line_read,
        input  line_addr,
        output line_rdata,
        output line_resp
    );
endinterface

interface pmem_burst_if;
    import cache_pkg::*;

    logic  pmem_read;
    addr_t pmem_addr;
    beat_t pmem_rdata;
    logic  pmem_resp;

    modport master (
        output pmem_read,
        output pmem_addr,
        input  pmem_rdata,
        input  pmem_resp
    );

    modport slave (
        input  pmem_read,
        input  pmem_addr,
        output pmem_rdata,
        output pmem_resp
    );
endinterface

// File: rtl/i_cache_line_adaptor_line_assembler.sv
// Collects in-order memory beats into one cache line.
// Data slices hold until overwritten; only the count is cleared.
module line_assembler
    import cache_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_clear,
    input  logic  i_beat_valid,
    input  beat_t i_beat_data,
    output line_t o_line,
    output logic  o_last_beat
);

    cnt_t  r_cnt;
    line_t r_line;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_line <= '0;
        end else begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_beat_valid) begin
                r_cnt <= r_cnt + 1'b1;
            end
            for (int k = 0; k < BEATS; k++) begin
                if (i_beat_valid && r_cnt == CNT_W'(k)) begin
                    r_line[k*BEAT_W +: BEAT_W] <= i_beat_data;
                end
            end
        end
    end

    assign o_line      = r_line;
    assign o_last_beat = (r_cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/i_cache_line_adaptor.sv
// Turns an I-cache line fill into a 4-beat memory read burst
// and returns the assembled line with a one-cycle completion pulse.
module i_cache_line_adaptor
    import cache_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    cache_line_if.slave  cache,
    pmem_burst_if.master pmem
);

    adaptor_state_e r_state;
    addr_t          r_addr;
    logic           r_pmem_read;
    logic           r_line_resp;

    logic  w_accept;
    logic  w_beat;
    logic  w_last;
    line_t w_line;

    assign w_accept = (r_state == IDLE) && cache.line_read;
    // Beats outside BURST never reach the assembler
    assign w_beat   = (r_state == BURST) && pmem.pmem_resp;

    line_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_accept),
        .i_beat_valid (w_beat),
        .i_beat_data  (pmem.pmem_rdata),
        .o_line       (w_line),
        .o_last_beat  (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_pmem_read <= 1'b0;
            r_line_resp <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (cache.line_read) begin
                        r_state     <= BURST;
                        r_addr      <= {cache.line_addr[ADDR_W-1:OFFSET_BITS],
                                        {OFFSET_BITS{1'b0}}};
                        r_pmem_read <= 1'b1;
                    end
                end
                BURST: begin
                    if (w_beat && w_last) begin
                        r_state     <= DONE;
                        r_pmem_read <= 1'b0;
                        r_line_resp <= 1'b1;
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_line_resp <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_pmem_read <= 1'b0;
                    r_line_resp <= 1'b0;
                end
            endcase
        end
    end

    assign pmem.pmem_read  = r_pmem_read;
    assign pmem.pmem_addr  = r_addr;
    assign cache.line_rdata = w_line;
    assign cache.line_resp  = r_line_resp;

endmodule

// File: tb/tb_i_cache_line_adaptor.sv
// Scoreboard bench for the I-cache line adaptor with a
// beat-queue memory model and directed line-fill scenarios.
module tb_i_cache_line_adaptor;

    logic clk;
    logic rst;

    cache_line_if cache ();
    pmem_burst_if pmem ();

    i_cache_line_adaptor dut (
        .clk   (clk),
        .rst   (rst),
        .cache (cache),
        .pmem  (pmem)
    );

    typedef struct {
        logic [255:0] line;
        int           req;
        int           lat;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mem_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          resp_count = 0;
    int          gap_cfg = 0;
    int          wait_cnt = 0;
    int          sent = 0;
    logic        mem_rd;
    logic        poke = 0;
    logic [63:0] poke_data = '0;
    logic [31:0] exp_addr = '0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Memory: one-cycle latency, at most 4 beats per burst, gap_cfg idle cycles between beats
    always @(posedge clk) begin
        mem_rd = pmem.pmem_read;
        #1;
        pmem.pmem_resp = 1'b0;
        if (poke) begin
            pmem.pmem_resp  = 1'b1;
            pmem.pmem_rdata = poke_data;
            poke = 1'b0;
        end else if (!mem_rd) begin
            sent     = 0;
            wait_cnt = 0;
        end else if (sent < 4 && mem_q.size() > 0) begin
            if (wait_cnt == 0) begin
                pmem.pmem_resp  = 1'b1;
                pmem.pmem_rdata = mem_q.pop_front();
                sent++;
                wait_cnt = gap_cfg;
            end else begin
                wait_cnt--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (pmem.pmem_read) begin
                n_tests++;
                if (pmem.pmem_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL pmem_addr got=%h exp=%h", pmem.pmem_addr, exp_addr);
                end
            end
            if (cache.line_resp) begin
                resp_count++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_resp at cyc=%0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (cache.line_rdata !== e.line) begin
                        n_fail++;
                        $display("FAIL line_rdata got=%h exp=%h", cache.line_rdata, e.line);
                    end
                    n_tests++;
                    if (cyc - e.req != e.lat) begin
                        n_fail++;
                        $display("FAIL latency got=%0d exp=%0d", cyc - e.req, e.lat);
                    end
                    n_tests++;
                    if (pmem.pmem_read !== 1'b0) begin
                        n_fail++;
                        $display("FAIL pmem_read_in_done got=%b exp=0", pmem.pmem_read);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic [31:0] a_mid,
                          input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3,
                          input int gap, input int lat, input logic [31:0] ea);
        exp_t e;
        bit   hi;
        bit   got;
        @(negedge clk);
        gap_cfg = gap;
        mem_q.push_back(b0);
        mem_q.push_back(b1);
        mem_q.push_back(b2);
        mem_q.push_back(b3);
        exp_addr = ea;
        e.line = {b3, b2, b1, b0};
        e.req  = cyc;
        e.lat  = lat;
        sb.push_back(e);
        cache.line_addr = a;
        cache.line_read = 1'b1;
        hi  = 1;
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (n == 2) cache.line_addr = a_mid;
            if (cache.line_resp) got = 1;
            else if (!pmem.pmem_read) hi = 0;
        end
        cache.line_read = 1'b0;
        check("resp_timeout", 256'(got), 256'(1));
        check("pmem_read_held", 256'(hi), 256'(1));
        @(negedge clk);
    endtask

    logic [255:0] line_a;
    logic [255:0] line_4;
    int           rc0;
    int           seen;

    initial begin
        rst = 1'b0;
        cache.line_read = 1'b0;
        cache.line_addr = '0;
        pmem.pmem_resp  = 1'b0;
        pmem.pmem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_pmem_read", 256'(pmem.pmem_read), 256'(0));
        check("rst_line_resp", 256'(cache.line_resp), 256'(0));
        check("rst_pmem_addr", 256'(pmem.pmem_addr), 256'(0));
        check("rst_line_rdata", cache.line_rdata, 256'(0));
        rst = 1'b1;
        @(negedge clk);

        line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        // Back-to-back beats
        do_req(32'h0000_104C, 32'h0000_104C, line_a[63:0], line_a[127:64],
               line_a[191:128], line_a[255:192], 0, 6, 32'h0000_1040);
        // Two wait states between beats
        do_req(32'h0000_104C, 32'h0000_104C, line_a[63:0], line_a[127:64],
               line_a[191:128], line_a[255:192], 2, 12, 32'h0000_1040);
        // Address changes mid-burst
        do_req(32'h0000_104C, 32'h0000_2000, 64'h5555_5555_5555_5555,
               64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777,
               64'h8888_8888_8888_8888, 0, 6, 32'h0000_1040);

        // Reset after the second beat of a burst
        rc0 = resp_count;
        @(negedge clk);
        gap_cfg = 0;
        mem_q.push_back(64'h9999_9999_9999_9999);
        mem_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
        exp_addr = 32'h0000_1000;
        cache.line_addr = 32'h0000_1010;
        cache.line_read = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        cache.line_read = 1'b0;
        #1;
        check("abort_pmem_read", 256'(pmem.pmem_read), 256'(0));
        check("abort_line_resp", 256'(cache.line_resp), 256'(0));
        check("abort_line_rdata", cache.line_rdata, 256'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("abort_no_resp", 256'(resp_count), 256'(rc0));
        line_4 = {64'hFFFF_FFFF_FFFF_FFFF, 64'hEEEE_EEEE_EEEE_EEEE,
                  64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC};
        do_req(32'h0000_0080, 32'h0000_0080, line_4[63:0], line_4[127:64],
               line_4[191:128], line_4[255:192], 0, 6, 32'h0000_0080);

        // Stray beat while idle
        rc0 = resp_count;
        @(negedge clk);
        poke_data = 64'hDEAD_BEEF_DEAD_BEEF;
        poke = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_beat_line", cache.line_rdata, line_4);
        check("idle_beat_pmem_read", 256'(pmem.pmem_read), 256'(0));
        check("idle_beat_no_resp", 256'(resp_count), 256'(rc0));

        // line_read held across line_resp: refetch starts after DONE
        rc0 = resp_count;
        @(negedge clk);
        gap_cfg = 0;
        mem_q.push_back(64'h0A0A_0A0A_0A0A_0A0A);
        mem_q.push_back(64'h0B0B_0B0B_0B0B_0B0B);
        mem_q.push_back(64'h0C0C_0C0C_0C0C_0C0C);
        mem_q.push_back(64'h0D0D_0D0D_0D0D_0D0D);
        mem_q.push_back(64'h1A1A_1A1A_1A1A_1A1A);
        mem_q.push_back(64'h1B1B_1B1B_1B1B_1B1B);
        mem_q.push_back(64'h1C1C_1C1C_1C1C_1C1C);
        mem_q.push_back(64'h1D1D_1D1D_1D1D_1D1D);
        exp_addr = 32'h0000_3000;
        sb.push_back('{line: {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
                              64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A},
                       req: cyc, lat: 6});
        sb.push_back('{line: {64'h1D1D_1D1D_1D1D_1D1D, 64'h1C1C_1C1C_1C1C_1C1C,
                              64'h1B1B_1B1B_1B1B_1B1B, 64'h1A1A_1A1A_1A1A_1A1A},
                       req: cyc, lat: 13});
        cache.line_addr = 32'h0000_3008;
        cache.line_read = 1'b1;
        seen = 0;
        for (int n = 0; n < 80 && seen < 2; n++) begin
            @(negedge clk);
            if (cache.line_resp) seen++;
        end
        cache.line_read = 1'b0;
        check("hold_two_resp", 256'(seen), 256'(2));
        repeat (10) @(negedge clk);
        check("hold_resp_count", 256'(resp_count), 256'(rc0 + 2));
        check("hold_mem_drained", 256'(mem_q.size()), 256'(0));

        repeat (3) @(negedge clk);
        check("sb_empty", 256'(sb.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
